// File: rtl/mul_sched_pkg.sv
// Shared types for the multiplier-sharing scheduler.
// Holds default sizing and the two pipeline-stage payload structs. The structs
// are sized from the defaults below, so a top-level WIDTH/NREQ override must be
// matched by changing DefWidth/DefNreq here.
package mul_sched_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefIdw   = $clog2(DefNreq);

  // Stage 1: operands presented to the shared datapath.
  typedef struct packed {
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
    logic                mode;
    logic [DefIdw-1:0]   id;
  } s1_t;

  // Stage 2: captured result waiting on the response channel.
  typedef struct packed {
    logic [2*DefWidth-1:0] p;
    logic                  ovf;
    logic [DefIdw-1:0]     id;
  } s2_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter (combinational).
// Searches req_i starting at index ptr_i upward with wrap and grants the first
// asserted request. The pointer register is owned by the caller.
//   req_i     : request vector
//   ptr_i     : search start index
//   en_i      : grant enable; no grant when low
//   gnt_o     : one-hot grant (or zero)
//   winner_o  : index of the granted request
//   any_gnt_o : a grant was issued
module rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  winner_o,
  output logic            any_gnt_o
);

  always_comb begin
    logic [IDW-1:0] idx;
    gnt_o     = '0;
    winner_o  = '0;
    any_gnt_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr_i) + i) % NREQ);
      if (en_i && !any_gnt_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        winner_o   = idx;
        any_gnt_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Time-shares one combinational multiplier datapath among NREQ requesters.
// A round-robin grant loads the winner's operands into stage 1, which drives
// the datapath; stage 2 captures the product and presents it on the response
// channel. Each op carries its requester ID and the per-requester approx mode.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o  : per-requester handshake; ready is one-hot or zero
//   req_a_i/req_b_i      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   cfg_we_i/cfg_approx_i: write the per-requester approx-mode register
//   mul_a_o/b_o/mode_o   : registered datapath inputs
//   mul_p_i/mul_ovf_i    : datapath result
//   rsp_*                : response channel
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic                  cfg_we_i,
  input  logic [NREQ-1:0]       cfg_approx_i,
  output logic [WIDTH-1:0]      mul_a_o,
  output logic [WIDTH-1:0]      mul_b_o,
  output logic                  mul_mode_o,
  input  logic [2*WIDTH-1:0]    mul_p_i,
  input  logic                  mul_ovf_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [2*WIDTH-1:0]    rsp_p_o,
  output logic                  rsp_ovf_o
);

  logic            s1_valid_q, s2_valid_q;
  s1_t             s1_q, s1_d;
  s2_t             s2_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] approx_q;

  logic            adv1, adv2;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  winner;
  logic            any_gnt;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  assign adv2 = !s2_valid_q || rsp_ready_i;
  assign adv1 = !s1_valid_q || adv2;

  // Gating with reset keeps req_ready low while the pipeline is being cleared.
  rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .en_i     (adv1 && !rst_i),
    .gnt_o    (gnt),
    .winner_o (winner),
    .any_gnt_o(any_gnt)
  );

  assign req_ready_o = gnt;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a_i[i*WIDTH +: WIDTH];
      b_arr[i] = req_b_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    s1_d.a    = a_arr[winner];
    s1_d.b    = b_arr[winner];
    s1_d.mode = approx_q[winner];  // pre-write value when cfg_we coincides
    s1_d.id   = winner;
    ptr_d     = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      ptr_q      <= '0;
      approx_q   <= '0;
    end else begin
      if (cfg_we_i) begin
        approx_q <= cfg_approx_i;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_q.p   <= mul_p_i;
          s2_q.ovf <= mul_ovf_i;
          s2_q.id  <= s1_q.id;
        end
      end
      // Without a grant S1 keeps its operands so the datapath output stays stable.
      if (adv1) begin
        s1_valid_q <= any_gnt;
        if (any_gnt) begin
          s1_q  <= s1_d;
          ptr_q <= ptr_d;
        end
      end
    end
  end

  assign mul_a_o     = s1_q.a;
  assign mul_b_o     = s1_q.b;
  assign mul_mode_o  = s1_q.mode;
  assign rsp_valid_o = s2_valid_q;
  assign rsp_id_o    = s2_q.id;
  assign rsp_p_o     = s2_q.p;
  assign rsp_ovf_o   = s2_q.ovf;

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  a_v [4];
  logic [7:0]  b_v [4];
  logic [31:0] req_a, req_b;
  logic        cfg_we;
  logic [3:0]  cfg_approx;
  logic [7:0]  mul_a, mul_b;
  logic        mul_mode;
  logic [15:0] mul_p;
  logic        mul_ovf;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic        rsp_ovf;

  always #5 clk = ~clk;

  assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

  // Stand-in datapath: approx mode drops the low nibble and flags it if lost.
  function automatic logic [15:0] dp_p(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    if (m) p[3:0] = 4'h0;
    return p;
  endfunction

  function automatic logic dp_ovf(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return m && (p[3:0] != 4'h0);
  endfunction

  assign mul_p   = dp_p(mul_a, mul_b, mul_mode);
  assign mul_ovf = dp_ovf(mul_a, mul_b, mul_mode);

  mul_share_sched #(
    .WIDTH(8),
    .NREQ (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .cfg_we_i    (cfg_we),
    .cfg_approx_i(cfg_approx),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_mode_o  (mul_mode),
    .mul_p_i     (mul_p),
    .mul_ovf_i   (mul_ovf),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_p_o     (rsp_p),
    .rsp_ovf_o   (rsp_ovf)
  );

  // Model: ordered list of in-flight ops; an op is visible at the head once it
  // has been in flight for two edges. Capacity two; accept needs room or a pop.
  typedef struct {
    int   id;
    logic [7:0] a;
    logic [7:0] b;
    logic mode;
    int   age;
  } item_t;

  typedef struct {
    int id;
    int p;
    int ovf;
    int cyc;
  } ev_t;

  item_t q[$];
  ev_t   grant_log[$];
  ev_t   rsp_log[$];
  ev_t   s1_log[$];
  int    mptr;
  logic [3:0] mapprox;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < 4; i++) begin
      if (req_valid[(mptr + i) % 4]) return (mptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    if (rst) return 4'b0;
    if (!(q.size() < 2 || rsp_ready)) return 4'b0;
    w = pick();
    if (w < 0) return 4'b0;
    return 4'(1 << w);
  endfunction

  function automatic int get_id(input ev_t l[$], input int i);
    if (i >= l.size()) return -1;
    return l[i].id;
  endfunction

  task automatic compare();
    logic  vis;
    item_t t;
    ev_t   e;
    check("req_ready", req_ready, exp_ready());
    vis = (q.size() > 0) && (q[0].age >= 2);
    check("rsp_valid", rsp_valid, vis);
    if (vis) begin
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_p", rsp_p, dp_p(q[0].a, q[0].b, q[0].mode));
      check("rsp_ovf", rsp_ovf, dp_ovf(q[0].a, q[0].b, q[0].mode));
    end
    if (q.size() > 0) begin
      t = q[q.size()-1];
      if (q.size() == 2 || t.age == 1) begin
        check("mul_a", mul_a, t.a);
        check("mul_b", mul_b, t.b);
        check("mul_mode", mul_mode, t.mode);
        if (t.age == 1) begin
          e = '{id: t.id, p: int'(mul_mode), ovf: 0, cyc: cyc};
          s1_log.push_back(e);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        e = '{id: i, p: 0, ovf: 0, cyc: cyc};
        grant_log.push_back(e);
      end
    end
    if (rsp_valid && rsp_ready) begin
      e = '{id: int'(rsp_id), p: int'(rsp_p), ovf: int'(rsp_ovf), cyc: cyc};
      rsp_log.push_back(e);
    end
  endtask

  task automatic model_update();
    logic  vis, fire, allowed;
    int    w;
    item_t it;
    if (rst) begin
      q.delete();
      mptr    = 0;
      mapprox = 4'b0;
      return;
    end
    vis     = (q.size() > 0) && (q[0].age >= 2);
    fire    = vis && rsp_ready;
    allowed = (q.size() < 2) || rsp_ready;
    w       = pick();
    if (fire) void'(q.pop_front());
    if (allowed && w >= 0) begin
      it = '{id: w, a: a_v[w], b: b_v[w], mode: mapprox[w], age: 0};
      q.push_back(it);
      mptr = (w + 1) % 4;
    end
    foreach (q[i]) q[i].age++;
    if (cfg_we) mapprox = cfg_approx;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    cyc++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_log.delete();
    s1_log.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0;
    cfg_we    = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b0;
    cfg_we     = 1'b0;
    cfg_approx = 4'b0;
    rsp_ready  = 1'b1;
    mptr       = 0;
    mapprox    = 4'b0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'(i + 1);
      b_v[i] = 8'(10 + i);
    end

    // Reset state
    do_reset();
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);

    // Single requester, exact: 13*11 = 143 two edges after acceptance
    a_v[0] = 8'd13; b_v[0] = 8'd11;
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();
    check("t1_grants", grant_log.size(), 1);
    check("t1_grant_id", get_id(grant_log, 0), 0);
    check("t1_rsp_cnt", rsp_log.size(), 1);
    if (rsp_log.size() == 1 && grant_log.size() == 1) begin
      check("t1_rsp_p", rsp_log[0].p, 143);
      check("t1_rsp_id", rsp_log[0].id, 0);
      check("t1_latency", rsp_log[0].cyc - grant_log[0].cyc, 2);
    end
    check("t1_mode", (s1_log.size() > 0) ? s1_log[0].p : -1, 0);

    // All requesters: grant and response order 0,1,2,3,0,1
    do_reset();
    a_v[0] = 8'd1;
    b_v[0] = 8'd10;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();
    check("t2_grants", grant_log.size(), 6);
    check("t2_rsps", rsp_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_grant_order", get_id(grant_log, i), i % 4);
      check("t2_rsp_order", get_id(rsp_log, i), i % 4);
    end
    if (rsp_log.size() == 6) check("t2_back_to_back", rsp_log[5].cyc - rsp_log[0].cyc, 5);

    // Backpressure with both stages full, then release
    do_reset();
    a_v[0] = 8'd255; b_v[0] = 8'd255;
    a_v[2] = 8'd255; b_v[2] = 8'd255;
    rsp_ready = 1'b0;
    req_valid = 4'b0101;
    for (int i = 0; i < 3; i++) cycle();
    check("t3_stall_p_a", rsp_p, 65025);
    cycle();
    cycle();
    check("t3_stall_grants", grant_log.size(), 2);
    check("t3_stall_valid", rsp_valid, 1);
    check("t3_stall_p_b", rsp_p, 65025);
    rsp_ready = 1'b1;
    cycle();
    check("t3_release_grants", grant_log.size(), 3);
    check("t3_release_winner", get_id(grant_log, 2), 0);
    for (int i = 0; i < 3; i++) cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) cycle();
    check("t3_rsp_cnt", rsp_log.size(), 6);
    check("t3_rsp0", get_id(rsp_log, 0), 0);
    check("t3_rsp1", get_id(rsp_log, 1), 2);
    for (int i = 0; i < 6; i++) check("t3_order", get_id(rsp_log, i), get_id(grant_log, i));

    // Approx-mode write coinciding with a grant
    do_reset();
    a_v[1] = 8'd200; b_v[1] = 8'd7;
    a_v[0] = 8'd3;   b_v[0] = 8'd5;
    req_valid  = 4'b0010;
    cfg_we     = 1'b1;
    cfg_approx = 4'b0010;
    cycle();
    cfg_we    = 1'b0;
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();
    check("t4_s1_cnt", s1_log.size(), 4);
    if (s1_log.size() == 4) begin
      check("t4_id0", s1_log[0].id, 1);
      check("t4_mode0", s1_log[0].p, 0);
      check("t4_mode1", s1_log[1].p, 0);
      check("t4_id2", s1_log[2].id, 1);
      check("t4_mode2", s1_log[2].p, 1);
      check("t4_mode3", s1_log[3].p, 0);
    end
    if (rsp_log.size() == 4) begin
      check("t4_exact_p", rsp_log[0].p, 1400);
      check("t4_exact_ovf", rsp_log[0].ovf, 0);
      check("t4_approx_p", rsp_log[2].p, 1392);
      check("t4_approx_ovf", rsp_log[2].ovf, 1);
      check("t4_req0_p", rsp_log[1].p, 15);
    end else begin
      check("t4_rsp_cnt", rsp_log.size(), 4);
    end
    cfg_approx = 4'b0000;

    // Reset with both stages occupied
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    check("t5_pre_valid", rsp_valid, 1);
    rst = 1'b1;
    cycle();
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_mul_a", mul_a, 0);
    check("t5_mul_b", mul_b, 0);
    rst = 1'b0;
    clear_logs();
    rsp_ready = 1'b1;
    req_valid = 4'b1110;
    cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();
    check("t5_first_grant", get_id(grant_log, 0), 1);
    check("t5_rsp_cnt", rsp_log.size(), 1);
    check("t5_rsp_id", get_id(rsp_log, 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
